// File: rtl/gonso_multi_regbank.sv
// gonso_multi_regbank: Wishbone register bank fronting NCH compute-core channels.
// Each channel snapshots its operand, runs a req/ready then result handshake, and reports status.
module gonso_multi_regbank #(
  parameter logic [31:0] BASE_ADDR = 32'h3003_0000,
  parameter int unsigned NCH       = 4,
  parameter int unsigned DW        = 20,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic [31:0]       wishbone_address,
  input  logic              wbs_we_i,
  input  logic [31:0]       wbs_dat_i,
  input  logic [3:0]        wbs_sel_i,
  output logic [31:0]       wbs_dat_o,
  output logic              wbs_ack_o,
  output logic [NCH*DW-1:0] core_in_o,
  output logic [NCH-1:0]    core_valid_o,
  input  logic [NCH-1:0]    core_ready_i,
  input  logic [NCH*DW-1:0] core_res_i,
  input  logic [NCH-1:0]    core_res_valid_i
);

  localparam logic [31:0] ID_VAL = 32'h474E_5302;
  localparam int unsigned CW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TLIM   = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam bit          TO_EN  = (TIMEOUT > 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } ch_state_e;

  // Registered state
  logic              ack_q, ack_d;
  logic [31:0]       dat_q, dat_d;
  logic [NCH-1:0]    auto_q, auto_d;
  logic [NCH-1:0]    done_q, done_d;
  logic [NCH-1:0]    to_q, to_d;
  logic [NCH-1:0]    ovr_q, ovr_d;
  logic [NCH-1:0]    valid_q, valid_d;
  logic [NCH*DW-1:0] cin_q, cin_d;
  logic [DW-1:0]     in_q  [NCH];
  logic [DW-1:0]     in_d  [NCH];
  logic [DW-1:0]     out_q [NCH];
  logic [DW-1:0]     out_d [NCH];
  logic [CW-1:0]     cnt_q [NCH];
  logic [CW-1:0]     cnt_d [NCH];
  ch_state_e         st_q  [NCH];
  ch_state_e         st_d  [NCH];

  // Decode and bus-side signals
  logic [31:0]       off;
  logic [29:0]       wrd;
  logic              acc, wr;
  logic [31:0]       wmask, wdat, rdata;
  logic              id_sel, ctrl_sel, stat_sel;
  logic [NCH-1:0]    in_sel, out_sel, busy, start_ev, tmo;
  logic              unused_bits;

  // Address decode, write mask and read mux; reads always see pre-edge values
  always_comb begin
    in_sel  = '0;
    out_sel = '0;
    busy    = '0;
    rdata   = '0;
    off     = wishbone_address - BASE_ADDR;
    wrd     = off[31:2];
    acc     = wbs_cyc_i & wbs_stb_i & ~ack_q;
    wr      = acc & wbs_we_i;
    for (int b = 0; b < 4; b++) begin
      wmask[b*8 +: 8] = {8{wbs_sel_i[b] & wr}};
    end
    wdat     = wbs_dat_i & wmask;
    id_sel   = (wrd == 30'd0);
    ctrl_sel = (wrd == 30'd1);
    stat_sel = (wrd == 30'd2);
    for (int k = 0; k < NCH; k++) begin
      in_sel[k]  = (wrd == 30'(4 + 2*k));
      out_sel[k] = (wrd == 30'(5 + 2*k));
      busy[k]    = (st_q[k] != S_IDLE);
    end
    if (id_sel)   rdata = ID_VAL;
    if (ctrl_sel) rdata = 32'(auto_q);
    if (stat_sel) rdata = {8'(ovr_q), 8'(to_q), 8'(done_q), 8'(busy)};
    for (int k = 0; k < NCH; k++) begin
      if (in_sel[k])  rdata = 32'(in_q[k]);
      if (out_sel[k]) rdata = 32'(out_q[k]);
    end
  end

  assign unused_bits = ^{off[1:0], wdat};

  // Bus handshake and software-written registers
  always_comb begin
    ack_d  = 1'b0;
    dat_d  = dat_q;
    auto_d = auto_q;
    in_d   = in_q;
    if (acc) begin
      ack_d = 1'b1;
      dat_d = rdata;
    end
    if (ctrl_sel) auto_d = (auto_q & ~wmask[NCH-1:0]) | wdat[NCH-1:0];
    for (int k = 0; k < NCH; k++) begin
      if (in_sel[k]) in_d[k] = (in_q[k] & ~wmask[DW-1:0]) | wdat[DW-1:0];
    end
  end

  // Channel FSMs: status W1C is applied first so any set on the same edge wins
  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    cin_d    = cin_q;
    out_d    = out_q;
    start_ev = '0;
    tmo      = '0;
    done_d   = done_q;
    to_d     = to_q;
    ovr_d    = ovr_q;
    for (int k = 0; k < NCH; k++) begin
      if (stat_sel) begin
        done_d[k] = done_q[k] & ~wdat[8+k];
        to_d[k]   = to_q[k]   & ~wdat[16+k];
        ovr_d[k]  = ovr_q[k]  & ~wdat[24+k];
      end
      start_ev[k] = (ctrl_sel & wdat[8+k]) | (wr & in_sel[k] & auto_q[k]);
      tmo[k]      = TO_EN && (cnt_q[k] == CW'(TLIM));
      case (st_q[k])
        S_IDLE: begin
          if (start_ev[k]) begin
            cin_d[k*DW +: DW] = in_d[k];
            valid_d[k]        = 1'b1;
            done_d[k]         = 1'b0;
            cnt_d[k]          = '0;
            st_d[k]           = S_REQ;
          end
        end
        S_REQ: begin
          if (start_ev[k]) ovr_d[k] = 1'b1;
          if (tmo[k]) begin
            valid_d[k] = 1'b0;
            to_d[k]    = 1'b1;
            st_d[k]    = S_IDLE;
          end else begin
            cnt_d[k] = cnt_q[k] + CW'(1);
            if (core_ready_i[k]) begin
              valid_d[k] = 1'b0;
              st_d[k]    = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (start_ev[k]) ovr_d[k] = 1'b1;
          if (core_res_valid_i[k]) begin
            out_d[k]  = core_res_i[k*DW +: DW];
            done_d[k] = 1'b1;
            st_d[k]   = S_IDLE;
          end else if (tmo[k]) begin
            to_d[k] = 1'b1;
            st_d[k] = S_IDLE;
          end else begin
            cnt_d[k] = cnt_q[k] + CW'(1);
          end
        end
        default: st_d[k] = S_IDLE;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q   <= 1'b0;
      dat_q   <= '0;
      auto_q  <= '0;
      done_q  <= '0;
      to_q    <= '0;
      ovr_q   <= '0;
      valid_q <= '0;
      cin_q   <= '0;
      in_q    <= '{default: '0};
      out_q   <= '{default: '0};
      cnt_q   <= '{default: '0};
      st_q    <= '{default: S_IDLE};
    end else begin
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      auto_q  <= auto_d;
      done_q  <= done_d;
      to_q    <= to_d;
      ovr_q   <= ovr_d;
      valid_q <= valid_d;
      cin_q   <= cin_d;
      in_q    <= in_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      st_q    <= st_d;
    end
  end

  assign wbs_ack_o    = ack_q;
  assign wbs_dat_o    = dat_q;
  assign core_valid_o = valid_q;
  assign core_in_o    = cin_q;

endmodule

// File: tb/tb_gonso_multi_regbank.sv
// tb_gonso_multi_regbank: scoreboarded bus reads plus direct core-side checks for the register bank.
module tb_gonso_multi_regbank;

  localparam int unsigned NCH  = 4;
  localparam int unsigned DW   = 20;
  localparam logic [31:0] BASE = 32'h3003_0000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [31:0]       wishbone_address, wbs_dat_i, wbs_dat_o;
  logic [3:0]        wbs_sel_i;
  logic              wbs_ack_o;
  logic [NCH*DW-1:0] core_in_o, core_res_i;
  logic [NCH-1:0]    core_valid_o, core_ready_i, core_res_valid_i;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  bit          cmp_q[$];
  string       tag_q[$];
  logic [31:0] mon_exp;
  bit          mon_cmp;
  string       mon_tag;

  gonso_multi_regbank #(
    .BASE_ADDR(BASE), .NCH(NCH), .DW(DW), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i),
    .wishbone_address(wishbone_address), .wbs_we_i(wbs_we_i),
    .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
    .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o),
    .core_in_o(core_in_o), .core_valid_o(core_valid_o),
    .core_ready_i(core_ready_i), .core_res_i(core_res_i),
    .core_res_valid_i(core_res_valid_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cin(input int k);
    return 32'(core_in_o[k*DW +: DW]);
  endfunction

  task automatic set_res(input int k, input logic [31:0] val, input logic v);
    core_res_i[k*DW +: DW] = DW'(val);
    core_res_valid_i[k]    = v;
  endtask

  // Drive one access; returns 1 time unit after the acking edge
  task automatic wb(input logic [31:0] off, input logic we, input logic [31:0] dat,
                    input logic [3:0] sel, input logic [31:0] exp, input string tag);
    int n;
    @(negedge clk);
    wishbone_address = BASE + off;
    wbs_we_i  = we;
    wbs_dat_i = dat;
    wbs_sel_i = sel;
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    exp_q.push_back(exp);
    cmp_q.push_back(!we);
    tag_q.push_back(tag);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!wbs_ack_o && n < 8);
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
    if (!wbs_ack_o) begin
      check({tag, "_noack"}, 32'd0, 32'd1);
      void'(exp_q.pop_back());
      void'(cmp_q.pop_back());
      void'(tag_q.pop_back());
    end
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] dat, input logic [3:0] sel);
    wb(off, 1'b1, dat, sel, 32'd0, "wr");
  endtask

  task automatic rd(input logic [31:0] off, input logic [31:0] exp, input string tag);
    wb(off, 1'b0, 32'd0, 4'hF, exp, tag);
  endtask

  // Scoreboard: every ack pops the expectation pushed when the access was driven
  always @(negedge clk) begin
    if (wbs_ack_o) begin
      if (exp_q.size() == 0) begin
        check("spurious_ack", 32'd1, 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_cmp = cmp_q.pop_front();
        mon_tag = tag_q.pop_front();
        if (mon_cmp) check(mon_tag, wbs_dat_o, mon_exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst_n = 1'b0;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wishbone_address = '0; wbs_dat_i = '0; wbs_sel_i = '0;
    core_ready_i = '0; core_res_i = '0; core_res_valid_i = '0;

    // 1: reset state, ID/STATUS reads, single-cycle ack
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(core_valid_o), 32'd0);
    check("rst_core_in", cin(0) | cin(3), 32'd0);
    check("rst_ack", 32'(wbs_ack_o), 32'd0);
    check("rst_dat", wbs_dat_o, 32'd0);
    rst_n = 1'b1;
    rd(32'h00, 32'h474E_5302, "t1_id");
    check("t1_ack_hi", 32'(wbs_ack_o), 32'd1);
    @(posedge clk);
    #1;
    check("t1_ack_lo", 32'(wbs_ack_o), 32'd0);
    rd(32'h08, 32'h0, "t1_status");

    // 2: software start of ch0, OUT read on the completion edge sees the old value
    wr(32'h10, 32'h12345, 4'hF);
    wr(32'h04, 32'h100, 4'hF);
    @(negedge clk);
    check("t2_valid", 32'(core_valid_o[0]), 32'd1);
    check("t2_snap", cin(0), 32'h12345);
    @(posedge clk);
    #1;
    core_ready_i[0] = 1'b1;
    @(negedge clk);
    check("t2_snap_held", cin(0), 32'h12345);
    check("t2_valid_held", 32'(core_valid_o[0]), 32'd1);
    @(posedge clk);
    #1;
    core_ready_i[0] = 1'b0;
    @(negedge clk);
    check("t2_valid_drop", 32'(core_valid_o[0]), 32'd0);
    @(posedge clk);
    #1;
    set_res(0, 32'h12346, 1'b1);
    rd(32'h14, 32'h0, "t2_out_old");
    set_res(0, 32'h0, 1'b0);
    rd(32'h14, 32'h12346, "t2_out");
    rd(32'h08, 32'h100, "t2_status");

    // 3: auto-start via partial-lane IN_1 write
    wr(32'h04, 32'h3, 4'hF);
    wr(32'h18, 32'hABCDE, 4'b0011);
    @(negedge clk);
    check("t3_valid1", 32'(core_valid_o[1]), 32'd1);
    check("t3_valid0", 32'(core_valid_o[0]), 32'd0);
    check("t3_snap1", cin(1), 32'h0BCDE);
    rd(32'h18, 32'h0BCDE, "t3_in1");
    rd(32'h08, 32'h102, "t3_status_busy");
    core_ready_i[1] = 1'b1;
    @(posedge clk);
    #1;
    core_ready_i[1] = 1'b0;
    set_res(1, 32'h0BCDF, 1'b1);
    @(posedge clk);
    #1;
    set_res(1, 32'h0, 1'b0);
    rd(32'h1C, 32'h0BCDF, "t3_out1");
    rd(32'h08, 32'h300, "t3_status_done");

    // 4: timeout with the core never ready, then W1C
    wr(32'h04, 32'h100, 4'hF);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (core_valid_o[0]) cnt++;
      else break;
    end
    check("t4_valid_cycles", 32'(cnt), 32'd16);
    rd(32'h08, 32'h10200, "t4_status_to");
    wr(32'h08, 32'h10000, 4'hF);
    rd(32'h08, 32'h200, "t4_status_w1c");

    // 4b: result arrives on the timeout edge and wins
    wr(32'h04, 32'h100, 4'hF);
    core_ready_i[0] = 1'b1;
    @(posedge clk);
    #1;
    core_ready_i[0] = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    set_res(0, 32'h0AAAA, 1'b1);
    @(posedge clk);
    #1;
    set_res(0, 32'h0, 1'b0);
    rd(32'h08, 32'h300, "t4b_status");
    rd(32'h14, 32'h0AAAA, "t4b_out0");

    // 5: start while busy sets overrun, snapshot kept; unmapped address
    wr(32'h20, 32'h11111, 4'hF);
    wr(32'h04, 32'h400, 4'hF);
    wr(32'h04, 32'h004, 4'hF);
    wr(32'h20, 32'h22222, 4'hF);
    @(negedge clk);
    check("t5_snap_kept", cin(2), 32'h11111);
    check("t5_valid2", 32'(core_valid_o[2]), 32'd1);
    rd(32'h20, 32'h22222, "t5_in2");
    rd(32'h08, 32'h0400_0304, "t5_status_ovr");
    wr(32'h40, 32'hFFFF_FFFF, 4'hF);
    rd(32'h40, 32'h0, "t5_unmapped");
    wr(32'h04, 32'h0, 4'hF);
    repeat (20) @(posedge clk);
    rd(32'h08, 32'h0404_0300, "t5_status_to");

    // 6: reset while ch3 waits for its result; late result ignored
    wr(32'h28, 32'h33333, 4'hF);
    wr(32'h04, 32'h800, 4'hF);
    core_ready_i[3] = 1'b1;
    @(posedge clk);
    #1;
    core_ready_i[3] = 1'b0;
    rd(32'h08, 32'h0404_0308, "t6_status_wait");
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(core_valid_o), 32'd0);
    check("t6_rst_snap", cin(3), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_res(3, 32'h77777, 1'b1);
    @(posedge clk);
    #1;
    set_res(3, 32'h0, 1'b0);
    rd(32'h2C, 32'h0, "t6_out3");
    rd(32'h08, 32'h0, "t6_status");
    check("t6_valid_after", 32'(core_valid_o), 32'd0);

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
